// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 response codes and SRAM subordinate FSM state types
//
// Purpose: common typedefs for the AXI4 SRAM subordinate and its sub-modules.
// Ports:   none (package).

package axi4_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic {
      W_COLLECT = 1'b0,
      W_RESP    = 1'b1
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } rd_state_e;

endpackage

// File: rtl/axi4_sram_array.sv
// rtl/axi4_sram_array.sv - byte-enabled single-port-write / sync-read word array
//
// Purpose: DEPTH x DATA_W storage with one byte-masked write port and one
//          registered read port. A read and write to the same word on the
//          same edge returns the pre-write contents.
// Ports:
//   clk_i    clock, rising edge
//   we_i     write enable (commits on this edge)
//   waddr_i  write word index
//   wstrb_i  per-byte write enable
//   wdata_i  write data
//   re_i     read enable; rdata_o updates only when set
//   raddr_i  read word index
//   rdata_o  registered read data, held between reads

module axi4_sram_array #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 256,
   localparam int STRB_W = DATA_W / 8,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [STRB_W-1:0] wstrb_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wstrb_i[i]) begin
               mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Non-blocking sampling of mem_q gives read-old-on-collision.
   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_sram_subordinate.sv
// rtl/axi4_sram_subordinate.sv - single-beat AXI4 subordinate backed by on-chip SRAM
//
// Purpose: accepts AW/W in any order and commits with byte strobes, returns
//          B; accepts AR and returns R the next cycle. Addresses outside
//          [BASE_ADDR, BASE_ADDR + DEPTH*STRB_W) get DECERR with no side effect.
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   AWADDR/AWVALID/AWREADY       write address channel
//   WDATA/WSTRB/WVALID/WREADY    write data channel
//   BRESP/BVALID/BREADY          write response channel
//   ARADDR/ARVALID/ARREADY       read address channel
//   RDATA/RRESP/RVALID/RREADY    read data channel

module axi4_sram_subordinate
   import axi4_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 64,
   parameter int                DEPTH     = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0000_1000,
   localparam int               STRB_W    = DATA_W / 8
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [DATA_W-1:0] WDATA,
   input  logic [STRB_W-1:0] WSTRB,
   input  logic              WVALID,
   output logic              WREADY,
   output logic [1:0]        BRESP,
   output logic              BVALID,
   input  logic              BREADY,
   input  logic [ADDR_W-1:0] ARADDR,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [DATA_W-1:0] RDATA,
   output logic [1:0]        RRESP,
   output logic              RVALID,
   input  logic              RREADY
);

   localparam int OFF_LSB = $clog2(STRB_W);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(DEPTH * STRB_W);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a >= BASE_ADDR) && ({1'b0, a} < LIMIT);
   endfunction

   // Low byte-lane bits are dropped, so unaligned addresses act as aligned.
   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> OFF_LSB);
   endfunction

   // Held low through reset so no handshake is offered until the cycle after release.
   logic              live_q;

   wr_state_e         wr_state_q, wr_state_d;
   logic              aw_got_q, aw_got_d;
   logic              w_got_q, w_got_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic              bvalid_q, bvalid_d;
   resp_t             bresp_q, bresp_d;

   rd_state_e         rd_state_q, rd_state_d;
   logic              rvalid_q, rvalid_d;
   resp_t             rresp_q, rresp_d;
   logic              rdata_ok_q, rdata_ok_d;

   logic              aw_hs, w_hs, ar_hs;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_data;
   logic [STRB_W-1:0] cur_strb;
   logic              mem_we;
   logic              arr_re;
   logic [DATA_W-1:0] arr_rdata;

   assign AWREADY = live_q && (wr_state_q == W_COLLECT) && !aw_got_q;
   assign WREADY  = live_q && (wr_state_q == W_COLLECT) && !w_got_q;
   assign ARREADY = live_q && (rd_state_q == R_IDLE);

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign ar_hs = ARVALID && ARREADY;

   // Live channel payload wins while its latch is still empty, so a write can
   // commit in the same cycle as its last handshake.
   assign cur_addr = aw_got_q ? awaddr_q : AWADDR;
   assign cur_data = w_got_q  ? wdata_q  : WDATA;
   assign cur_strb = w_got_q  ? wstrb_q  : WSTRB;

   always_comb begin
      wr_state_d = wr_state_q;
      aw_got_d   = aw_got_q;
      w_got_d    = w_got_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      mem_we     = 1'b0;
      case (wr_state_q)
         W_COLLECT: begin
            if (aw_hs) begin
               aw_got_d = 1'b1;
               awaddr_d = AWADDR;
            end
            if (w_hs) begin
               w_got_d = 1'b1;
               wdata_d = WDATA;
               wstrb_d = WSTRB;
            end
            if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
               mem_we     = in_range(cur_addr);
               bresp_d    = in_range(cur_addr) ? OKAY : DECERR;
               bvalid_d   = 1'b1;
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (BREADY) begin
               bvalid_d   = 1'b0;
               aw_got_d   = 1'b0;
               w_got_d    = 1'b0;
               wr_state_d = W_COLLECT;
            end
         end
         default: wr_state_d = W_COLLECT;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      rdata_ok_d = rdata_ok_q;
      arr_re     = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               arr_re     = in_range(ARADDR);
               rvalid_d   = 1'b1;
               rresp_d    = in_range(ARADDR) ? OKAY : DECERR;
               rdata_ok_d = in_range(ARADDR);
               rd_state_d = R_RESP;
            end
         end
         R_RESP: begin
            if (RREADY) begin
               rvalid_d   = 1'b0;
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         live_q     <= 1'b0;
         wr_state_q <= W_COLLECT;
         aw_got_q   <= 1'b0;
         w_got_q    <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= OKAY;
         rd_state_q <= R_IDLE;
         rvalid_q   <= 1'b0;
         rresp_q    <= OKAY;
         rdata_ok_q <= 1'b0;
      end else begin
         live_q     <= 1'b1;
         wr_state_q <= wr_state_d;
         aw_got_q   <= aw_got_d;
         w_got_q    <= w_got_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rd_state_q <= rd_state_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_ok_q <= rdata_ok_d;
      end
   end

   axi4_sram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk_i   (ACLK),
      .we_i    (mem_we && !ARESET),
      .waddr_i (word_idx(cur_addr)),
      .wstrb_i (cur_strb),
      .wdata_i (cur_data),
      .re_i    (arr_re),
      .raddr_i (word_idx(ARADDR)),
      .rdata_o (arr_rdata)
   );

   assign BVALID = bvalid_q;
   assign BRESP  = bresp_q;
   assign RVALID = rvalid_q;
   assign RRESP  = rresp_q;
   // Array output is registered; DECERR and reset force the visible data to zero.
   assign RDATA  = rdata_ok_q ? arr_rdata : '0;

endmodule

// File: tb/tb_axi4_sram_subordinate.sv
// tb/tb_axi4_sram_subordinate.sv - directed self-checking bench for axi4_sram_subordinate

module tb_axi4_sram_subordinate;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [63:0] WDATA;
   logic [7:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [63:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   int checks = 0;
   int errors = 0;

   always #5 ACLK = ~ACLK;

   axi4_sram_subordinate #(
      .ADDR_W    (32),
      .DATA_W    (64),
      .DEPTH     (256),
      .BASE_ADDR (32'h0000_1000)
   ) dut (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .AWADDR  (AWADDR),
      .AWVALID (AWVALID),
      .AWREADY (AWREADY),
      .WDATA   (WDATA),
      .WSTRB   (WSTRB),
      .WVALID  (WVALID),
      .WREADY  (WREADY),
      .BRESP   (BRESP),
      .BVALID  (BVALID),
      .BREADY  (BREADY),
      .ARADDR  (ARADDR),
      .ARVALID (ARVALID),
      .ARREADY (ARREADY),
      .RDATA   (RDATA),
      .RRESP   (RRESP),
      .RVALID  (RVALID),
      .RREADY  (RREADY)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // AW and W presented together; B accepted immediately.
   task automatic wr_same(input string tag, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic [1:0] exp_resp);
      AWADDR = a; AWVALID = 1'b1;
      WDATA = d; WSTRB = s; WVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0;
      chk({tag, "_bvalid"}, BVALID, 1'b1);
      chk({tag, "_bresp"}, BRESP, exp_resp);
      step();
      chk({tag, "_bdone"}, {BVALID, AWREADY, WREADY}, 3'b011);
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [63:0] exp_d,
                     input logic [1:0] exp_resp);
      ARADDR = a; ARVALID = 1'b1;
      step();
      ARVALID = 1'b0;
      chk({tag, "_rvalid"}, {RVALID, ARREADY}, 2'b10);
      chk({tag, "_rdata"}, RDATA, exp_d);
      chk({tag, "_rresp"}, RRESP, exp_resp);
      step();
      chk({tag, "_rdone"}, {RVALID, ARREADY}, 2'b01);
   endtask

   initial begin
      // Reset held three cycles with every valid asserted.
      ARESET = 1'b1;
      AWADDR = 32'h1000; AWVALID = 1'b1;
      WDATA = 64'hFFFF_FFFF_FFFF_FFFF; WSTRB = 8'hFF; WVALID = 1'b1;
      ARADDR = 32'h1000; ARVALID = 1'b1;
      BREADY = 1'b1; RREADY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_hold", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b00000);
      end
      chk("rst_payload", {BRESP, RRESP}, 4'b0000);
      chk("rst_rdata", RDATA, 64'h0);
      ARESET = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      step();
      chk("rst_release", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);
      step();
      step();
      chk("rst_no_resp", {BVALID, RVALID}, 2'b00);

      // Known content at the window base for later no-side-effect checks.
      wr_same("base_wr", 32'h1000, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00);

      // AW first, W three cycles later.
      AWADDR = 32'h1008; AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      chk("aw_first_held", {AWREADY, WREADY, BVALID}, 3'b010);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("aw_first_wait", BVALID, 1'b0);
      end
      WDATA = 64'h1122_3344_5566_7788; WSTRB = 8'hFF; WVALID = 1'b1;
      step();
      WVALID = 1'b0;
      chk("aw_first_b", {BVALID, BRESP, AWREADY, WREADY}, 5'b10000);
      step();
      chk("aw_first_bdone", {BVALID, AWREADY, WREADY}, 3'b011);
      rd("aw_first_rd", 32'h1008, 64'h1122_3344_5566_7788, 2'b00);

      // W first with partial strobe, then AW after a gap.
      WDATA = 64'hAAAA_AAAA_BBBB_BBBB; WSTRB = 8'h0F; WVALID = 1'b1;
      step();
      WVALID = 1'b0;
      chk("w_first_held", {AWREADY, WREADY, BVALID}, 3'b100);
      step();
      AWADDR = 32'h1008; AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      chk("w_first_b", {BVALID, BRESP}, 3'b100);
      step();
      rd("strb_rd", 32'h1008, 64'h1122_3344_BBBB_BBBB, 2'b00);

      // Unaligned address maps onto the same word.
      rd("unaligned_rd", 32'h100B, 64'h1122_3344_BBBB_BBBB, 2'b00);

      // Out of window on both sides.
      wr_same("oor_wr", 32'h1800, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 2'b11);
      rd("oor_rd", 32'h0FF8, 64'h0, 2'b11);
      rd("base_intact", 32'h1000, 64'h0123_4567_89AB_CDEF, 2'b00);

      // Last word in the window.
      wr_same("top_wr", 32'h17F8, 64'h5555_6666_7777_8888, 8'hFF, 2'b00);
      rd("top_rd", 32'h17F8, 64'h5555_6666_7777_8888, 2'b00);

      // Backpressure on both response channels.
      BREADY = 1'b0; RREADY = 1'b0;
      AWADDR = 32'h1018; WDATA = 64'hCAFE_F00D_1234_5678; WSTRB = 8'hFF;
      AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 32'h1008; ARVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid_rdy", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b11000);
         chk("bp_resp", {BRESP, RRESP}, 4'b0000);
         chk("bp_rdata", RDATA, 64'h1122_3344_BBBB_BBBB);
      end
      BREADY = 1'b1; RREADY = 1'b1;
      step();
      chk("bp_release", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b00111);
      rd("bp_rd", 32'h1018, 64'hCAFE_F00D_1234_5678, 2'b00);

      // Read and write to the same word committing on the same edge.
      wr_same("col_old", 32'h1010, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 2'b00);
      AWADDR = 32'h1010; WDATA = 64'h5A5A_5A5A_5A5A_5A5A; WSTRB = 8'hFF;
      AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 32'h1010; ARVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      chk("col_valids", {BVALID, RVALID}, 2'b11);
      chk("col_rdata_old", RDATA, 64'hA5A5_A5A5_A5A5_A5A5);
      step();
      rd("col_new", 32'h1010, 64'h5A5A_5A5A_5A5A_5A5A, 2'b00);

      // Reset while B is pending.
      BREADY = 1'b0;
      AWADDR = 32'h1020; WDATA = 64'h1; WSTRB = 8'hFF;
      AWVALID = 1'b1; WVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0;
      chk("mid_rst_b", BVALID, 1'b1);
      ARESET = 1'b1;
      step();
      chk("mid_rst_drop", {BVALID, AWREADY, WREADY, ARREADY}, 4'b0000);
      ARESET = 1'b0; BREADY = 1'b1;
      step();
      chk("mid_rst_release", {BVALID, AWREADY, WREADY, ARREADY}, 4'b0111);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mid_rst_no_resp", {BVALID, RVALID}, 2'b00);
      end

      // A lone AW is discarded by reset.
      AWADDR = 32'h1028; AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      chk("part_aw_held", AWREADY, 1'b0);
      ARESET = 1'b1;
      step();
      ARESET = 1'b0;
      step();
      chk("part_cleared", {AWREADY, WREADY}, 2'b11);
      WDATA = 64'h0BAD_C0DE_0BAD_C0DE; WSTRB = 8'hFF; WVALID = 1'b1;
      step();
      WVALID = 1'b0;
      chk("part_w_only", {BVALID, AWREADY, WREADY}, 3'b010);
      AWADDR = 32'h1028; AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      chk("part_complete", {BVALID, BRESP}, 3'b100);
      step();
      rd("part_rd", 32'h1028, 64'h0BAD_C0DE_0BAD_C0DE, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
